// File: rtl/conv_layer_engine.sv
// conv_layer_engine: address and strobe sequencer for one convolution layer.
// It walks every output window (oc, oy, ox) and each kernel tap (ky, kx),
// issuing one read per cycle. It then delays the read strobe to drive the MAC
// enables and the result write.
// Optional build macro CONV_STALL_EN adds a 'stall' input. While stall is high
// in RUN or DRAIN, the sequencer and its delay pipeline freeze.
module conv_layer_engine #(
    parameter int IN_W   = 32,
    parameter int K      = 5,
    parameter int OUT_CH = 6,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef CONV_STALL_EN
    input  logic              stall,
`endif
    output logic              done,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              rd_en,
    output logic              mac_en,
    output logic              mac_first,
    output logic [ADDR_W-1:0] out_addr,
    output logic              wr_en
);

    localparam int OUT_W = IN_W - K + 1;
    localparam int KCW   = (K > 1)      ? $clog2(K)      : 1;
    localparam int OWCW  = (OUT_W > 1)  ? $clog2(OUT_W)  : 1;
    localparam int OCCW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    localparam logic [KCW-1:0]  K_MAX  = KCW'(K - 1);
    localparam logic [OWCW-1:0] OW_MAX = OWCW'(OUT_W - 1);
    localparam logic [OCCW-1:0] OC_MAX = OCCW'(OUT_CH - 1);

    localparam logic [ADDR_W-1:0] A_IN_W = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] A_K    = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] A_KK   = ADDR_W'(K * K);
    localparam logic [ADDR_W-1:0] A_OW   = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] A_OWW  = ADDR_W'(OUT_W * OUT_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic   drain_q, drain_d;

    logic [KCW-1:0]  kx_q, kx_d, ky_q, ky_d;
    logic [OWCW-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [OCCW-1:0] oc_q, oc_d;

    // Read-to-MAC stage (1-cycle memory latency) and MAC-to-write stage
    logic              v1_q, v1_d;
    logic              first1_q, first1_d;
    logic              last1_q, last1_d;
    logic [ADDR_W-1:0] oaddr1_q, oaddr1_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] oaddr2_q, oaddr2_d;

    logic              stall_w;
    logic              active;
    logic              freeze;
    logic              abort;
    logic              fire;
    logic              last_rd;
    logic [ADDR_W-1:0] win_oaddr;

`ifdef CONV_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign active  = (state_q == RUN) || (state_q == DRAIN);
    assign freeze  = stall_w && active;
    assign abort   = active && !en;
    assign fire    = (state_q == RUN) && !freeze;
    assign last_rd = (kx_q == K_MAX) && (ky_q == K_MAX) && (ox_q == OW_MAX) &&
                     (oy_q == OW_MAX) && (oc_q == OC_MAX);

    // Read and window addresses derived directly from the loop counters
    always_comb begin
        in_addr   = (ADDR_W'(oy_q) + ADDR_W'(ky_q)) * A_IN_W + ADDR_W'(ox_q) + ADDR_W'(kx_q);
        w_addr    = ADDR_W'(oc_q) * A_KK + ADDR_W'(ky_q) * A_K + ADDR_W'(kx_q);
        win_oaddr = ADDR_W'(oc_q) * A_OWW + ADDR_W'(oy_q) * A_OW + ADDR_W'(ox_q);
    end

    // Layer FSM next-state; en low aborts even while stalled
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                drain_d = 1'b0;
                if (!en)                  state_d = IDLE;
                else if (fire && last_rd) state_d = DRAIN;
            end
            DRAIN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!freeze) begin
                    if (drain_q) state_d = DONE;
                    else         drain_d = 1'b1;
                end
            end
            DONE: begin
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Nested kx/ky/ox/oy/oc counters, one step per issued read
    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        oc_d = oc_q;
        if (abort) begin
            kx_d = '0;
            ky_d = '0;
            ox_d = '0;
            oy_d = '0;
            oc_d = '0;
        end else if (fire) begin
            if (kx_q != K_MAX) begin
                kx_d = kx_q + 1'b1;
            end else begin
                kx_d = '0;
                if (ky_q != K_MAX) begin
                    ky_d = ky_q + 1'b1;
                end else begin
                    ky_d = '0;
                    if (ox_q != OW_MAX) begin
                        ox_d = ox_q + 1'b1;
                    end else begin
                        ox_d = '0;
                        if (oy_q != OW_MAX) begin
                            oy_d = oy_q + 1'b1;
                        end else begin
                            oy_d = '0;
                            if (oc_q != OC_MAX) oc_d = oc_q + 1'b1;
                            else                oc_d = '0;
                        end
                    end
                end
            end
        end
    end

    // Delay pipeline carrying read qualifiers to the MAC and write stages
    always_comb begin
        v1_d     = v1_q;
        first1_d = first1_q;
        last1_d  = last1_q;
        oaddr1_d = oaddr1_q;
        wr_d     = wr_q;
        oaddr2_d = oaddr2_q;
        if (abort) begin
            v1_d     = 1'b0;
            first1_d = 1'b0;
            last1_d  = 1'b0;
            wr_d     = 1'b0;
        end else if (!freeze) begin
            v1_d     = fire;
            first1_d = fire && (kx_q == '0) && (ky_q == '0);
            last1_d  = fire && (kx_q == K_MAX) && (ky_q == K_MAX);
            oaddr1_d = win_oaddr;
            wr_d     = v1_q && last1_q;
            if (v1_q && last1_q) oaddr2_d = oaddr1_q;
        end
    end

    // Output strobes are masked while frozen so nothing is consumed twice
    always_comb begin
        done      = (state_q == DONE);
        rd_en     = fire;
        mac_en    = v1_q && !freeze;
        mac_first = v1_q && first1_q && !freeze;
        wr_en     = wr_q && !freeze;
        out_addr  = oaddr2_q;
    end

    // State, counter and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            drain_q  <= 1'b0;
            kx_q     <= '0;
            ky_q     <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            oc_q     <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            oaddr1_q <= '0;
            wr_q     <= 1'b0;
            oaddr2_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            kx_q     <= kx_d;
            ky_q     <= ky_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            oc_q     <= oc_d;
            v1_q     <= v1_d;
            first1_q <= first1_d;
            last1_q  <= last1_d;
            oaddr1_q <= oaddr1_d;
            wr_q     <= wr_d;
            oaddr2_q <= oaddr2_d;
        end
    end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Testbench for conv_layer_engine (IN_W=4, K=2, OUT_CH=1).
// A monitor logs every read, MAC and write event with its cycle number. Each
// layer run is then compared against a timeline computed from the
// convolution loop definition.
`timescale 1ns/1ps
module tb_conv_layer_engine;

    localparam int IN_W   = 4;
    localparam int K      = 2;
    localparam int OUT_CH = 1;
    localparam int ADDR_W = 13;
    localparam int OW     = IN_W - K + 1;
    localparam int KK     = K * K;
    localparam int NRD    = OUT_CH * OW * OW * KK;
    localparam int NWIN   = OUT_CH * OW * OW;
    localparam int NEVER  = 32'h3fff_ffff;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
`ifdef CONV_STALL_EN
    logic              stall;
`endif
    logic              done;
    logic [ADDR_W-1:0] in_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              rd_en;
    logic              mac_en;
    logic              mac_first;
    logic [ADDR_W-1:0] out_addr;
    logic              wr_en;

    conv_layer_engine #(
        .IN_W  (IN_W),
        .K     (K),
        .OUT_CH(OUT_CH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
`ifdef CONV_STALL_EN
        .stall    (stall),
`endif
        .done     (done),
        .in_addr  (in_addr),
        .w_addr   (w_addr),
        .rd_en    (rd_en),
        .mac_en   (mac_en),
        .mac_first(mac_first),
        .out_addr (out_addr),
        .wr_en    (wr_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cyc[$], rd_ia[$], rd_wa[$];
    int mac_cyc[$], mac_fst[$];
    int wr_cyc[$], wr_oa[$];
    int done_first = -1;

    // Event logger, sampled on the inactive clock edge
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_ia.push_back(int'(in_addr));
            rd_wa.push_back(int'(w_addr));
        end
        if (mac_en === 1'b1) begin
            mac_cyc.push_back(cyc);
            mac_fst.push_back(int'(mac_first));
        end
        if (wr_en === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_oa.push_back(int'(out_addr));
        end
        if (done === 1'b1 && done_first < 0) done_first = cyc;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Timeline of the current run: c0 is the cycle of the first read. A stall
    // of stall_len cycles starting at nominal offset stall_at delays every
    // later event.
    int c0;
    int stall_at;
    int stall_len;

    function automatic int when(input int n);
        return c0 + n + ((stall_len > 0 && n >= stall_at) ? stall_len : 0);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"},      int'(done),      0);
        check({tag, "_rd_en"},     int'(rd_en),     0);
        check({tag, "_mac_en"},    int'(mac_en),    0);
        check({tag, "_mac_first"}, int'(mac_first), 0);
        check({tag, "_wr_en"},     int'(wr_en),     0);
        check({tag, "_in_addr"},   int'(in_addr),   0);
        check({tag, "_w_addr"},    int'(w_addr),    0);
        check({tag, "_out_addr"},  int'(out_addr),  0);
    endtask

    // Events whose time falls at or after 'cut' are expected to be dropped
    task automatic compare_logs(input int cut, input bit expect_done);
        int ec[$], ea[$], eb[$];
        int idx;
        idx = 0;
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int oy = 0; oy < OW; oy++)
                for (int ox = 0; ox < OW; ox++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            if (when(idx) < cut) begin
                                ec.push_back(when(idx));
                                ea.push_back((oy + ky) * IN_W + ox + kx);
                                eb.push_back(oc * KK + ky * K + kx);
                            end
                            idx++;
                        end
        check("rd_count", rd_cyc.size(), ec.size());
        for (int i = 0; i < ec.size() && i < rd_cyc.size(); i++) begin
            check("rd_cycle",   rd_cyc[i], ec[i]);
            check("rd_in_addr", rd_ia[i],  ea[i]);
            check("rd_w_addr",  rd_wa[i],  eb[i]);
        end

        ec.delete(); ea.delete();
        for (int i = 0; i < NRD; i++)
            if (when(i + 1) < cut) begin
                ec.push_back(when(i + 1));
                ea.push_back((i % KK == 0) ? 1 : 0);
            end
        check("mac_count", mac_cyc.size(), ec.size());
        for (int i = 0; i < ec.size() && i < mac_cyc.size(); i++) begin
            check("mac_cycle", mac_cyc[i], ec[i]);
            check("mac_first", mac_fst[i], ea[i]);
        end

        ec.delete(); ea.delete();
        idx = 0;
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int oy = 0; oy < OW; oy++)
                for (int ox = 0; ox < OW; ox++) begin
                    if (when((idx + 1) * KK + 1) < cut) begin
                        ec.push_back(when((idx + 1) * KK + 1));
                        ea.push_back(oc * OW * OW + oy * OW + ox);
                    end
                    idx++;
                end
        check("wr_count", wr_cyc.size(), ec.size());
        for (int i = 0; i < ec.size() && i < wr_cyc.size(); i++) begin
            check("wr_cycle",    wr_cyc[i], ec[i]);
            check("wr_out_addr", wr_oa[i],  ea[i]);
        end

        check("done_cycle", done_first, expect_done ? when(NRD + 2) : -1);
    endtask

    task automatic wait_reads(input int k, output bit ok);
        int b;
        b = 0;
        while (rd_cyc.size() < k && b < 500) begin
            @(negedge clk); #1;
            b++;
        end
        ok = (rd_cyc.size() >= k);
    endtask

    // mode 0: full layer, 1: en dropped at read k, 2: rst at read k,
    // 3: stall for L cycles at read k
    task automatic run_layer(input int mode, input int k, input int L);
        bit ok;
        int cut;
        int b;
        int hold;
        rd_cyc.delete(); rd_ia.delete(); rd_wa.delete();
        mac_cyc.delete(); mac_fst.delete();
        wr_cyc.delete(); wr_oa.delete();
        done_first = -1;
        stall_at   = 0;
        stall_len  = 0;
        cut        = NEVER;

        @(posedge clk); #1;
        en = 1'b1;
        c0 = cyc + 1;

        if (mode != 0) begin
            wait_reads(k, ok);
            check("reach_read_k", int'(ok), 1);
            @(posedge clk); #1;
            if (mode == 1) begin
                en  = 1'b0;
                cut = cyc + 1;
            end else if (mode == 2) begin
                rst = 1'b1;
                cut = cyc + 1;
                @(posedge clk);
                @(negedge clk);
                check_outputs_zero("after_rst");
                rst = 1'b0;
                en  = 1'b0;
            end else begin
`ifdef CONV_STALL_EN
                stall     = 1'b1;
                stall_at  = k;
                stall_len = L;
                for (int j = 0; j < L; j++) begin
                    @(negedge clk);
                    check("stall_rd_en",  int'(rd_en),  0);
                    check("stall_mac_en", int'(mac_en), 0);
                    check("stall_wr_en",  int'(wr_en),  0);
                end
                @(posedge clk); #1;
                stall = 1'b0;
`endif
            end
        end

        if (mode == 0 || mode == 3) begin
            b = 0;
            while (done_first < 0 && b < 300) begin
                @(negedge clk); #1;
                b++;
            end
            check("done_reached", int'(done_first >= 0), 1);
            hold = $urandom_range(2, 8);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                check("hold_done",  int'(done),  1);
                check("hold_rd_en", int'(rd_en), 0);
            end
            @(posedge clk); #1;
            en = 1'b0;
            @(negedge clk);
            check("done_before_drop", int'(done), 1);
            @(negedge clk);
            check("done_after_drop", int'(done), 0);
        end else begin
            repeat (12) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        compare_logs(cut, (mode == 0 || mode == 3));
    endtask

    initial begin
        int m;
        int k;
        int L;
        rst = 1'b1;
        en  = 1'b0;
`ifdef CONV_STALL_EN
        stall = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        run_layer(0, 0, 0);
        run_layer(1, 10, 0);
        run_layer(0, 0, 0);
        run_layer(2, 20, 0);
        run_layer(0, 0, 0);
`ifdef CONV_STALL_EN
        run_layer(3, 7, 3);
`endif
        for (int r = 0; r < 6; r++) begin
`ifdef CONV_STALL_EN
            m = $urandom_range(0, 3);
`else
            m = $urandom_range(0, 2);
`endif
            k = $urandom_range(2, 30);
            L = $urandom_range(1, 5);
            run_layer(m, k, L);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/conv_layer_engine.md
CONV_LAYER_ENGINE -- requirements
Module: conv_layer_engine

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, meaning input feature-map width and height in pixels.
REQ-002 The block SHALL have parameter K, default 5, meaning kernel width and height.
REQ-003 The block SHALL have parameter OUT_CH, default 6, meaning number of output channels.
REQ-004 The block SHALL have parameter ADDR_W, default 13, meaning the width of all address outputs.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit, a layer-enable level from the top sequencer.
REQ-008 The block SHALL have port done, output, 1 bit, a layer-complete level.
REQ-009 The block SHALL have port in_addr, output, ADDR_W bits, the input-pixel read address.
REQ-010 The block SHALL have port w_addr, output, ADDR_W bits, the weight read address.
REQ-011 The block SHALL have port rd_en, output, 1 bit, which qualifies in_addr and w_addr.
REQ-012 The block SHALL have port mac_en, output, 1 bit, meaning "accumulate this cycle's read data".
REQ-013 The block SHALL have port mac_first, output, 1 bit, meaning "load instead of accumulate", valid with mac_en.
REQ-014 The block SHALL have port out_addr, output, ADDR_W bits, the result write address.
REQ-015 The block SHALL have port wr_en, output, 1 bit, the result write strobe.

Function
REQ-016 OUT_W SHALL equal IN_W-K+1, and all address arithmetic SHALL be unsigned and truncated to ADDR_W bits.
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, and SHALL reset to IDLE.
REQ-018 The FSM SHALL move from IDLE to RUN on the first clock edge where en=1.
REQ-019 The FSM SHALL move from RUN to DRAIN after the last read is issued.
REQ-020 The FSM SHALL move from DRAIN to DONE after 2 cycles.
REQ-021 The FSM SHALL move from DONE to IDLE on the first edge where en=0.
REQ-022 In RUN, the block SHALL assert rd_en every cycle and issue exactly one read per cycle.
REQ-023 The read counter nesting SHALL be, innermost first: kx, ky, ox, oy, oc, with each counter wrapping to 0 and carrying to the next.
REQ-024 The read addresses SHALL be in_addr=(oy+ky)*IN_W+(ox+kx) and w_addr=oc*K*K+ky*K+kx.
REQ-025 Total reads per layer SHALL be OUT_CH*OUT_W*OUT_W*K*K, with no bubbles.
REQ-026 mac_en SHALL equal rd_en delayed 1 cycle, matching the 1-cycle memory read latency.
REQ-027 mac_first SHALL be asserted with the mac_en of each window's kx=0,ky=0 read.
REQ-028 wr_en SHALL pulse 2 cycles after each window's kx=K-1,ky=K-1 read.
REQ-029 out_addr SHALL equal oc*OUT_W*OUT_W+oy*OUT_W+ox of that window, valid with wr_en.
REQ-030 done SHALL be 1 only in DONE, and SHALL be held as a level until en falls.
REQ-031 If en falls in RUN or DRAIN, the block SHALL abort to IDLE on that edge, and rd_en, mac_en and wr_en SHALL be 0 from the next cycle; in-flight results SHALL be dropped.
REQ-032 If en is held high through DONE, the block SHALL NOT restart; a new layer SHALL require en to go 0 and then 1.

Reset
REQ-033 On rst=1 at a clock edge, the FSM SHALL go to IDLE, all counters and pipeline delay registers SHALL clear, and done, rd_en, mac_en, mac_first and wr_en SHALL be 0, with all addresses 0.
REQ-034 rst mid-operation SHALL take priority over en, and no wr_en SHALL follow it.

Configuration
REQ-035 With macro CONV_STALL_EN defined, the block SHALL add input port stall (1 bit); while stall=1 in RUN or DRAIN, all counters, the FSM and the delay pipeline SHALL freeze, and rd_en, mac_en and wr_en SHALL be forced to 0.
REQ-036 When stall falls, the block SHALL resume with no lost or duplicated reads.
REQ-037 Without CONV_STALL_EN, the stall port SHALL NOT exist and the block SHALL never freeze.

Verification (IN_W=4, K=2, OUT_CH=1, so OUT_W=3, 36 reads)
REQ-038 Scenario: reset, then en=1 held -> 36 consecutive rd_en cycles, the first with in_addr=0,w_addr=0 and the last with in_addr=15,w_addr=3; 9 wr_en pulses with out_addr 0..8; done=1 3 cycles after the last read.
REQ-039 Scenario: window ox=1,oy=0 -> in_addr sequence 1,2,5,6; mac_first on the mac_en matching in_addr=1; wr_en with out_addr=1 2 cycles after in_addr=6.
REQ-040 Scenario: en dropped at read 10 -> IDLE on the next edge; no further rd_en or wr_en; done stays 0; re-assertion of en restarts at in_addr=0.
REQ-041 Scenario: en held 5 cycles after done -> done stays 1 with no reads; en=0 -> done=0 next cycle.
REQ-042 Scenario: rst=1 at read 20 -> all outputs 0 on the next cycle, and no wr_en for the interrupted window.
REQ-043 Scenario (CONV_STALL_EN): stall=1 for 3 cycles at read 7 -> rd_en=0 for 3 cycles; total reads still 36 and wr_en pulses still 9.
